// File: rtl/z80_io_console.sv
// Z80 I/O-mapped console: data port pushes into a TX FIFO, data-port reads
// drain a single-entry RX holding register, status port reports FIFO/RX/overflow.
module z80_io_console #(
    parameter logic [7:0] PORT_BASE  = 8'h10,
    parameter int         FIFO_DEPTH = 16,
    parameter int         AW         = 4
) (
    input  logic       eclk,
    input  logic       _ereset,
    input  logic [7:0] ab,
    input  logic [7:0] db_o,
    output logic [7:0] db_i,
    output logic       db_t,
    input  logic       _iorq,
    input  logic       _rd,
    input  logic       _wr,
    input  logic       _m1,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    input  logic       tx_ready,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic       rx_ready
);

    localparam logic [7:0]  STAT_PORT = PORT_BASE + 8'd1;
    localparam logic [AW:0] DEPTH_C   = (AW+1)'(FIFO_DEPTH);

    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          ovf_q, ovf_d;
    logic          rx_full_q, rx_full_d;
    logic [7:0]    rx_reg_q, rx_reg_d;
    logic          wr_act_q, rd_act_q;
    logic          db_t_q, db_t_d;
    logic [7:0]    db_i_q, db_i_d;
    // Which port the current read targets, and whether RX held a byte at its start.
    logic          rd_hit_q, rd_hit_d;
    logic          rd_data_q, rd_data_d;
    logic          rd_rxf_q, rd_rxf_d;

    logic       wr_act, rd_act;
    logic       hit_data, hit_stat;
    logic       wr_rise, rd_rise, rd_fall;
    logic       tx_empty, tx_full;
    logic       push_req, push_ok, pop, rx_load;
    logic [7:0] status;

    assign wr_act   = !_iorq && !_wr && _m1;
    assign rd_act   = !_iorq && !_rd && _m1;
    assign hit_data = (ab == PORT_BASE);
    assign hit_stat = (ab == STAT_PORT);
    assign wr_rise  = wr_act && !wr_act_q;
    assign rd_rise  = rd_act && !rd_act_q;
    assign rd_fall  = !rd_act && rd_act_q;

    assign tx_empty = (count_q == '0);
    assign tx_full  = (count_q == DEPTH_C);
    assign tx_valid = !tx_empty;
    assign tx_data  = mem_q[rd_ptr_q];
    assign rx_ready = !rx_full_q;
    assign db_t     = db_t_q;
    assign db_i     = db_i_q;

    assign pop      = tx_valid && tx_ready;
    assign push_req = wr_rise && hit_data;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign push_ok  = push_req && (!tx_full || pop);
    assign rx_load  = rx_valid && rx_ready;
    assign status   = {4'b0000, ovf_q, rx_full_q, tx_empty, tx_full};

    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        ovf_d     = ovf_q;
        rx_full_d = rx_full_q;
        rx_reg_d  = rx_reg_q;
        db_t_d    = db_t_q;
        db_i_d    = db_i_q;
        rd_hit_d  = rd_hit_q;
        rd_data_d = rd_data_q;
        rd_rxf_d  = rd_rxf_q;

        if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop)     rd_ptr_d = rd_ptr_q + 1'b1;
        case ({push_ok, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        if (rd_rise) begin
            rd_hit_d  = hit_data || hit_stat;
            rd_data_d = hit_data;
            rd_rxf_d  = rx_full_q;
            if (hit_data || hit_stat) begin
                db_t_d = 1'b1;
                db_i_d = hit_data ? rx_reg_q : status;
            end
        end

        if (rd_fall) begin
            db_t_d   = 1'b0;
            rd_hit_d = 1'b0;
            if (rd_hit_q && rd_data_q && rd_rxf_q) rx_full_d = 1'b0;
            if (rd_hit_q && !rd_data_q)            ovf_d     = 1'b0;
        end

        if (wr_rise && hit_stat && db_o[3]) ovf_d = 1'b0;
        if (push_req && tx_full && !pop)    ovf_d = 1'b1;

        if (rx_load) begin
            rx_full_d = 1'b1;
            rx_reg_d  = rx_data;
        end
    end

    always_ff @(posedge eclk or negedge _ereset) begin
        if (!_ereset) begin
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= 8'h00;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            ovf_q     <= 1'b0;
            rx_full_q <= 1'b0;
            rx_reg_q  <= 8'h00;
            wr_act_q  <= 1'b0;
            rd_act_q  <= 1'b0;
            db_t_q    <= 1'b0;
            db_i_q    <= 8'h00;
            rd_hit_q  <= 1'b0;
            rd_data_q <= 1'b0;
            rd_rxf_q  <= 1'b0;
        end else begin
            if (push_ok) mem_q[wr_ptr_q] <= db_o;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            ovf_q     <= ovf_d;
            rx_full_q <= rx_full_d;
            rx_reg_q  <= rx_reg_d;
            wr_act_q  <= wr_act;
            rd_act_q  <= rd_act;
            db_t_q    <= db_t_d;
            db_i_q    <= db_i_d;
            rd_hit_q  <= rd_hit_d;
            rd_data_q <= rd_data_d;
            rd_rxf_q  <= rd_rxf_d;
        end
    end

endmodule

// File: tb/tb_z80_io_console.sv
// Directed bench for z80_io_console: a table of bus cycles plus hand-written
// sequences for overflow, full push/pop, RX hand-off and mid-cycle reset.
module tb_z80_io_console;

    logic       eclk = 1'b0;
    logic       _ereset;
    logic [7:0] ab, db_o, db_i, tx_data, rx_data;
    logic       db_t, _iorq, _rd, _wr, _m1, tx_valid, tx_ready, rx_valid, rx_ready;

    int n_pass  = 0;
    int n_total = 0;

    z80_io_console dut (
        .eclk(eclk), ._ereset(_ereset), .ab(ab), .db_o(db_o), .db_i(db_i), .db_t(db_t),
        ._iorq(_iorq), ._rd(_rd), ._wr(_wr), ._m1(_m1),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready)
    );

    always #5 eclk = ~eclk;

    typedef struct {
        bit         is_rd;
        logic [7:0] addr;
        logic [7:0] data;
        bit         m1;
        bit         exp_dbt;
        logic [7:0] exp_db;
        bit         exp_txv;
        logic [7:0] exp_txd;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %02h expected %02h", name, act, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge eclk);
        #1;
    endtask

    task automatic bus_write(input logic [7:0] addr, input logic [7:0] data, input bit m1);
        ab = addr; db_o = data; _m1 = m1; _iorq = 1'b0; _wr = 1'b0;
        tick(4);
        _iorq = 1'b1; _wr = 1'b1; _m1 = 1'b1;
        tick(1);
    endtask

    task automatic bus_read(input logic [7:0] addr, input bit m1, input bit exp_dbt,
                            input logic [7:0] exp_db, input string tag);
        ab = addr; _m1 = m1; _iorq = 1'b0; _rd = 1'b0;
        tick(1);
        check({tag, " db_t lead"}, {7'b0, db_t}, {7'b0, exp_dbt});
        if (exp_dbt) check({tag, " db_i"}, db_i, exp_db);
        tick(3);
        _iorq = 1'b1; _rd = 1'b1; _m1 = 1'b1;
        tick(1);
        check({tag, " db_t trail"}, {7'b0, db_t}, 8'h00);
    endtask

    initial begin
        _ereset = 1'b0; ab = 8'h00; db_o = 8'h00; _iorq = 1'b1; _rd = 1'b1; _wr = 1'b1;
        _m1 = 1'b1; tx_ready = 1'b0; rx_data = 8'h00; rx_valid = 1'b0;

        //             rd  addr   data   m1  dbt exp_db txv  txd
        vecs[0] = '{1'b1, 8'h11, 8'h00, 1'b1, 1'b1, 8'h02, 1'b0, 8'h00};
        vecs[1] = '{1'b0, 8'h10, 8'h41, 1'b1, 1'b0, 8'h00, 1'b1, 8'h41};
        vecs[2] = '{1'b0, 8'h10, 8'h42, 1'b1, 1'b0, 8'h00, 1'b1, 8'h41};
        vecs[3] = '{1'b0, 8'h10, 8'h43, 1'b1, 1'b0, 8'h00, 1'b1, 8'h41};
        vecs[4] = '{1'b1, 8'h11, 8'h00, 1'b1, 1'b1, 8'h00, 1'b1, 8'h41};
        vecs[5] = '{1'b0, 8'h10, 8'h99, 1'b0, 1'b0, 8'h00, 1'b1, 8'h41};
        vecs[6] = '{1'b0, 8'h12, 8'h77, 1'b1, 1'b0, 8'h00, 1'b1, 8'h41};
        vecs[7] = '{1'b1, 8'h12, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1, 8'h41};
        vecs[8] = '{1'b1, 8'h10, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1, 8'h41};

        // Reset state
        tick(3);
        check("rst tx_valid", {7'b0, tx_valid}, 8'h00);
        check("rst rx_ready", {7'b0, rx_ready}, 8'h01);
        check("rst db_t",     {7'b0, db_t},     8'h00);
        check("rst db_i",     db_i,             8'h00);
        check("rst tx_data",  tx_data,          8'h00);
        _ereset = 1'b1;
        tick(1);

        // Table-driven bus cycles: writes, status reads, M1 and address-miss cases
        for (int i = 0; i < 9; i++) begin
            if (vecs[i].is_rd)
                bus_read(vecs[i].addr, vecs[i].m1, vecs[i].exp_dbt, vecs[i].exp_db,
                         $sformatf("vec%0d", i));
            else
                bus_write(vecs[i].addr, vecs[i].data, vecs[i].m1);
            check($sformatf("vec%0d tx_valid", i), {7'b0, tx_valid}, {7'b0, vecs[i].exp_txv});
            check($sformatf("vec%0d tx_data", i), tx_data, vecs[i].exp_txd);
        end

        // Drain the three bytes in order
        tx_ready = 1'b1;
        tick(1); check("drain b1", tx_data, 8'h42);
        tick(1); check("drain b2", tx_data, 8'h43);
        tick(1); check("drain empty", {7'b0, tx_valid}, 8'h00);
        tx_ready = 1'b0;
        bus_read(8'h11, 1'b1, 1'b1, 8'h02, "stat idle");

        // Overflow: 17 writes into a 16-deep FIFO
        for (int i = 0; i < 17; i++) bus_write(8'h10, 8'(i), 1'b1);
        bus_read(8'h11, 1'b1, 1'b1, 8'h09, "stat ovf");
        bus_read(8'h11, 1'b1, 1'b1, 8'h01, "stat ovf cleared");
        tx_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            check($sformatf("ovf head%0d", i), tx_data, 8'(i));
            tick(1);
        end
        check("ovf 17th absent", {7'b0, tx_valid}, 8'h00);
        tx_ready = 1'b0;

        // Push into a full FIFO on the same cycle as a pop
        for (int i = 0; i < 16; i++) bus_write(8'h10, 8'(8'h20 + i), 1'b1);
        ab = 8'h10; db_o = 8'hAA; _iorq = 1'b0; _wr = 1'b0; tx_ready = 1'b1;
        tick(1);
        tx_ready = 1'b0; _iorq = 1'b1; _wr = 1'b1;
        tick(1);
        bus_read(8'h11, 1'b1, 1'b1, 8'h01, "stat full no ovf");
        tx_ready = 1'b1;
        for (int i = 0; i < 15; i++) begin
            check($sformatf("full head%0d", i), tx_data, 8'(8'h21 + i));
            tick(1);
        end
        check("full pushed byte", tx_data, 8'hAA);
        tick(1);
        check("full drained", {7'b0, tx_valid}, 8'h00);
        tx_ready = 1'b0;

        // RX holding register
        rx_data = 8'h5A; rx_valid = 1'b1;
        tick(1);
        rx_valid = 1'b0;
        check("rx loaded rx_ready", {7'b0, rx_ready}, 8'h00);
        bus_read(8'h11, 1'b1, 1'b1, 8'h06, "stat rx full");
        bus_read(8'h10, 1'b1, 1'b1, 8'h5A, "rx read");
        check("rx freed", {7'b0, rx_ready}, 8'h01);

        // New byte offered on the trailing-edge cycle of a data read
        rx_data = 8'h11; rx_valid = 1'b1;
        tick(1);
        rx_valid = 1'b0;
        ab = 8'h10; _iorq = 1'b0; _rd = 1'b0;
        tick(1);
        check("rx2 db_i", db_i, 8'h11);
        tick(1);
        _iorq = 1'b1; _rd = 1'b1; rx_data = 8'h66; rx_valid = 1'b1;
        tick(2);
        rx_valid = 1'b0;
        check("rx overlap full", {7'b0, rx_ready}, 8'h00);
        bus_read(8'h10, 1'b1, 1'b1, 8'h66, "rx overlap byte");
        bus_read(8'h10, 1'b1, 1'b1, 8'h66, "rx stale");
        check("rx stale no effect", {7'b0, rx_ready}, 8'h01);

        // Reset in the middle of a read and a drain
        for (int i = 0; i < 5; i++) bus_write(8'h10, 8'(8'h30 + i), 1'b1);
        rx_data = 8'h77; rx_valid = 1'b1;
        tick(1);
        rx_valid = 1'b0; tx_ready = 1'b1;
        tick(2);
        ab = 8'h10; _iorq = 1'b0; _rd = 1'b0;
        tick(1);
        check("mid db_t before rst", {7'b0, db_t}, 8'h01);
        _ereset = 1'b0;
        #1;
        check("mid rst db_t",     {7'b0, db_t},     8'h00);
        check("mid rst db_i",     db_i,             8'h00);
        check("mid rst tx_valid", {7'b0, tx_valid}, 8'h00);
        check("mid rst tx_data",  tx_data,          8'h00);
        check("mid rst rx_ready", {7'b0, rx_ready}, 8'h01);
        tick(2);
        tx_ready = 1'b0;
        _ereset = 1'b1;
        tick(1);
        check("post rst db_t", {7'b0, db_t}, 8'h01);
        check("post rst db_i", db_i, 8'h00);
        _iorq = 1'b1; _rd = 1'b1;
        tick(1);
        check("post rst db_t drop", {7'b0, db_t}, 8'h00);
        bus_read(8'h11, 1'b1, 1'b1, 8'h02, "post rst stat");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
